// File: rtl/fake_netlist_bist_pkg.sv
// Shared types and default constants for the fake-netlist BIST stage.
// Used by fake_netlist_bist_stim and fake_netlist_misr.
package fake_netlist_bist_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_CAPTURE,
    S_DONE
  } bist_state_t;

  localparam int          DEF_IN_W      = 13;
  localparam int          DEF_SIG_W     = 16;
  localparam logic [12:0] DEF_LFSR_POLY = 13'h100D;
  localparam logic [12:0] DEF_LFSR_SEED = 13'h0001;
  localparam logic [15:0] DEF_MISR_POLY = 16'h1021;

endpackage

// File: rtl/fake_netlist_misr.sv
// Single-input MISR compactor for the netlist response bit.
// clr has priority over en; en shifts one response bit in.
module fake_netlist_misr
  import fake_netlist_bist_pkg::*;
#(
  parameter int               SIG_W     = DEF_SIG_W,
  parameter logic [SIG_W-1:0] MISR_POLY = DEF_MISR_POLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] fb;

  assign fb = sig[SIG_W-1] ? MISR_POLY : '0;

  // signature register: clear on run start, shift on capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], 1'b0}
           ^ fb
           ^ SIG_W'(din);
    end
  end

endmodule

// File: rtl/fake_netlist_bist_stim.sv
// LFSR stimulus / MISR response BIST stage around a fake netlist.
// Build option: FAKE_NETLIST_BIST_ONES_CNT_EN enables ones_count.
module fake_netlist_bist_stim
  import fake_netlist_bist_pkg::*;
#(
  parameter int               IN_W      = DEF_IN_W,
  parameter logic [IN_W-1:0]  LFSR_POLY = DEF_LFSR_POLY,
  parameter logic [IN_W-1:0]  LFSR_SEED = DEF_LFSR_SEED,
  parameter int               SETTLE    = 2,
  parameter int               SIG_W     = DEF_SIG_W,
  parameter logic [SIG_W-1:0] MISR_POLY = DEF_MISR_POLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      num_patterns,
  output logic [IN_W-1:0]  stim,
  input  logic             resp,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic [15:0]      ones_count
);

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE);

  bist_state_t     state;
  bist_state_t     state_nxt;
  logic [15:0]     num_lat;
  logic [15:0]     pat_cnt;
  logic [7:0]      settle_cnt;
  logic [IN_W-1:0] lfsr_nxt;
  logic            run_go;
  logic            run_zero;
  logic            cap;
  logic            last;

  assign lfsr_nxt = {stim[IN_W-2:0], ^(stim & LFSR_POLY)};
  assign busy     = (state == S_APPLY) || (state == S_CAPTURE);
  assign done     = (state == S_DONE);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next state and per-cycle control strobes
  always_comb begin
    state_nxt = state;
    run_go    = 1'b0;
    run_zero  = 1'b0;
    cap       = 1'b0;
    last      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (num_patterns != 16'd0) begin
            run_go    = 1'b1;
            state_nxt = S_APPLY;
          end else begin
            run_zero  = 1'b1;
            state_nxt = S_DONE;
          end
        end
      end
      S_APPLY: begin
        if (abort)
          state_nxt = S_IDLE;
        else if (settle_cnt == 8'd1)
          state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else begin
          cap = 1'b1;
          if (pat_cnt + 16'd1 == num_lat) begin
            last      = 1'b1;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_APPLY;
          end
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // pattern source, settle timer and pattern counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stim       <= LFSR_SEED;
      num_lat    <= '0;
      pat_cnt    <= '0;
      settle_cnt <= '0;
    end else if (run_go) begin
      stim       <= LFSR_SEED;
      num_lat    <= num_patterns;
      pat_cnt    <= '0;
      settle_cnt <= SETTLE_LD;
    end else if (state == S_APPLY && !abort) begin
      settle_cnt <= settle_cnt - 8'd1;
    end else if (cap) begin
      pat_cnt <= pat_cnt + 16'd1;
      if (!last) begin
        stim       <= lfsr_nxt;
        settle_cnt <= SETTLE_LD;
      end
    end
  end

  fake_netlist_misr #(
    .SIG_W    (SIG_W),
    .MISR_POLY(MISR_POLY)
  ) u_misr (
    .clk(clk),
    .rst(rst),
    .clr(run_go | run_zero),
    .en (cap),
    .din(resp),
    .sig(signature)
  );

`ifdef FAKE_NETLIST_BIST_ONES_CNT_EN
  // saturating count of captured ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_count <= '0;
    end else if (run_go || run_zero) begin
      ones_count <= '0;
    end else if (cap && resp &&
                 ones_count != 16'hFFFF) begin
      ones_count <= ones_count + 16'd1;
    end
  end
`else
  assign ones_count = 16'h0000;
`endif

endmodule
